// File: rtl/half_joiner_pkg.sv
// Shared definitions for the half-word joiner: FSM state encodings, the
// error-counter width and a saturating-increment helper.
package half_joiner_pkg;

    // Receive FSM states. The encodings are fixed so that the other pipeline
    // stages can decode them the same way.
    typedef enum logic [1:0] {
        WAIT_LSB = 2'd0,
        WAIT_MSB = 2'd1,
        FULL     = 2'd2
    } state_e;

    // Width of the sequence-error counter.
    localparam int ERRCNT_W = 8;

    // Adds one and stops at all-ones.
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/half_joiner_if.sv
// Stream bundle for the half-word joiner: the narrow input stream, the wide
// output stream, flush, the error outputs and a debug view of the FSM state.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The sender holds data stable while valid is high and ready is low.
// ready may be high while valid is low. in_ready never looks at in_valid.
interface half_joiner_if
    import half_joiner_pkg::*;
#(
    parameter int nbits = 7
) ();

    logic                  flush;
    logic [nbits-1:0]      in_data;
    logic                  in_msb;
    logic                  in_valid;
    logic                  in_ready;
    logic [2*nbits-1:0]    out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  seq_err;
    logic [ERRCNT_W-1:0]   err_count;
    state_e                dbg_state;

    // Upstream producer plus downstream consumer side.
    modport master (
        output flush,
        output in_data,
        output in_msb,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  seq_err,
        input  err_count,
        input  dbg_state
    );

    // Joiner side.
    modport slave (
        input  flush,
        input  in_data,
        input  in_msb,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output seq_err,
        output err_count,
        output dbg_state
    );

endinterface

// File: rtl/half_joiner_sat_counter.sv
// Saturating event counter. It counts enable pulses and stops at all-ones.
// Only reset clears it.
module sat_counter
    import half_joiner_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    output logic [ERRCNT_W-1:0] count_o
);

    logic [ERRCNT_W-1:0] count_q;
    logic [ERRCNT_W-1:0] count_d;

    // Next count: step on enable, hold at the ceiling.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = sat_inc(count_q);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/half_joiner.sv
// half_joiner: rebuilds a 2*nbits word from an lsb half followed by an msb
// half arriving over a valid/ready stream. The word is presented on a
// registered valid/ready output as {msb, lsb}. A half that arrives out of
// order raises a one-cycle seq_err pulse.
// Optional feature: define HALF_JOINER_ERRCNT_EN to build the saturating
// error counter behind err_count. Otherwise err_count is tied to 0.
module half_joiner
    import half_joiner_pkg::*;
#(
    parameter int nbits = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    half_joiner_if.slave bus
);

    state_e               state_q;
    state_e               state_d;
    logic [nbits-1:0]     lsb_q;
    logic [nbits-1:0]     lsb_d;
    logic [2*nbits-1:0]   out_data_q;
    logic [2*nbits-1:0]   out_data_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic                 seq_err_q;
    logic                 seq_err_d;
    logic                 in_ready;
    logic                 in_xfer;
    logic                 out_xfer;

    // Input readiness. In FULL the block accepts a half only when the held
    // word leaves on the same edge. Flush blocks the input in every state.
    always_comb begin
        in_ready = !bus.flush && ((state_q != FULL) || bus.out_ready);
        in_xfer  = bus.in_valid && in_ready;
        out_xfer = out_valid_q && bus.out_ready;
    end

    // Next-state and register-input logic. Flush overrides every other event.
    always_comb begin
        state_d     = state_q;
        lsb_d       = lsb_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        seq_err_d   = 1'b0;

        if (bus.flush) begin
            state_d     = WAIT_LSB;
            out_valid_d = 1'b0;
            lsb_d       = '0;
        end else begin
            unique case (state_q)
                WAIT_LSB: begin
                    if (in_xfer) begin
                        if (!bus.in_msb) begin
                            lsb_d   = bus.in_data;
                            state_d = WAIT_MSB;
                        end else begin
                            // An msb without a preceding lsb is dropped.
                            seq_err_d = 1'b1;
                        end
                    end
                end
                WAIT_MSB: begin
                    if (in_xfer) begin
                        if (bus.in_msb) begin
                            out_data_d  = {bus.in_data, lsb_q};
                            out_valid_d = 1'b1;
                            state_d     = FULL;
                        end else begin
                            // A repeated lsb replaces the stored one.
                            lsb_d     = bus.in_data;
                            seq_err_d = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        out_valid_d = 1'b0;
                        state_d     = WAIT_LSB;
                        // A half taken on the draining edge starts the next word.
                        if (in_xfer) begin
                            if (!bus.in_msb) begin
                                lsb_d   = bus.in_data;
                                state_d = WAIT_MSB;
                            end else begin
                                seq_err_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d     = WAIT_LSB;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, partial-word and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LSB;
            lsb_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lsb_q       <= lsb_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.dbg_state = state_q;

`ifdef HALF_JOINER_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count;

    // The count steps on the same edge that raises seq_err.
    sat_counter u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (seq_err_d),
        .count_o (err_count)
    );

    assign bus.err_count = err_count;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_half_joiner.sv
// Bench for half_joiner: a per-cycle vector table with expected in_ready,
// seq_err and out_valid values, a queue of expected words, a mid-word reset
// sequence and an error-counter run.
module tb_half_joiner;
    import half_joiner_pkg::*;

`ifdef HALF_JOINER_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic        flush;
        logic        vld;
        logic        msb;
        logic [6:0]  data;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_err;
        logic        exp_ov;
        logic        push;
        logic        drop;
        logic [13:0] word;
    } vec_t;

    logic clk;
    logic rst_n;

    half_joiner_if #(.nbits(7)) bus ();

    half_joiner #(.nbits(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [13:0] exp_q[$];
    vec_t        vecs[$];
    int          n_cmp;
    int          n_bad;
    int          exp_cnt;

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic fl, logic vld, logic msb, logic [6:0] d, logic ordy,
                                logic e_rdy, logic e_err, logic e_ov, logic push,
                                logic drop, logic [13:0] w);
        vec_t v;
        v.flush = fl;  v.vld = vld;  v.msb = msb;  v.data = d;  v.ordy = ordy;
        v.exp_rdy = e_rdy;  v.exp_err = e_err;  v.exp_ov = e_ov;
        v.push = push;  v.drop = drop;  v.word = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_msb    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
    endtask

    // Apply one vector. Before the edge, check in_ready and score a word that
    // is leaving. After the edge, check seq_err, out_valid, out_data and err_count.
    task automatic apply_vec(input vec_t v);
        logic [13:0] w;
        @(negedge clk);
        bus.flush     = v.flush;
        bus.in_valid  = v.vld;
        bus.in_msb    = v.msb;
        bus.in_data   = v.data;
        bus.out_ready = v.ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(v.exp_rdy));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_word: got %0h, expected no word at %0t", bus.out_data, $time);
            end else begin
                w = exp_q.pop_front();
                chk("out_word", 32'(bus.out_data), 32'(w));
            end
        end
        if (v.push) exp_q.push_back(v.word);
        if (v.drop && exp_q.size() != 0) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        if (v.exp_err && CNT_ON && exp_cnt != 255) exp_cnt++;
        chk("seq_err", 32'(bus.seq_err), 32'(v.exp_err));
        chk("out_valid", 32'(bus.out_valid), 32'(v.exp_ov));
        if (v.exp_ov) chk("out_data_held", 32'(bus.out_data), 32'(v.word));
        chk("err_count", 32'(bus.err_count), 32'(exp_cnt));
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        drive_idle();

        // Basic word.
        vecs.push_back(mk(0,1,0,7'h15,1, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h2A,1, 1,0,1, 1,0,14'h1515));
        vecs.push_back(mk(0,0,0,7'h00,1, 1,0,0, 0,0,14'h0000));
        // Backpressure for 5 cycles with a pending lsb offered, then release.
        vecs.push_back(mk(0,1,0,7'h05,0, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h0A,0, 1,0,1, 1,0,14'h0505));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,7'h33,0, 0,0,1, 0,0,14'h0505));
        vecs.push_back(mk(0,1,0,7'h33,1, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h44,1, 1,0,1, 1,0,14'h2233));
        vecs.push_back(mk(0,0,0,7'h00,1, 1,0,0, 0,0,14'h0000));
        // msb first, then a good word.
        vecs.push_back(mk(0,1,1,7'h01,1, 1,1,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,0,7'h03,1, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h04,1, 1,0,1, 1,0,14'h0203));
        vecs.push_back(mk(0,0,0,7'h00,1, 1,0,0, 0,0,14'h0000));
        // Two lsbs, the newest one wins.
        vecs.push_back(mk(0,1,0,7'h10,1, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,0,7'h11,1, 1,1,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h00,1, 1,0,1, 1,0,14'h0011));
        // msb on the draining edge in FULL is treated as out of order.
        vecs.push_back(mk(0,1,1,7'h05,1, 1,1,0, 0,0,14'h0000));
        // Flush in WAIT_MSB; the following msb becomes an error.
        vecs.push_back(mk(0,1,0,7'h7F,1, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(1,0,0,7'h00,1, 0,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h01,1, 1,1,0, 0,0,14'h0000));
        // Flush together with a valid lsb: the lsb is ignored.
        vecs.push_back(mk(1,1,0,7'h22,1, 0,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h02,1, 1,1,0, 0,0,14'h0000));
        // Flush drops a held word.
        vecs.push_back(mk(0,1,0,7'h01,0, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h01,0, 1,0,1, 1,0,14'h0081));
        vecs.push_back(mk(1,0,0,7'h00,0, 0,0,0, 0,1,14'h0000));
        // Fill to FULL and offer an msb under backpressure.
        vecs.push_back(mk(0,1,0,7'h7E,0, 1,0,0, 0,0,14'h0000));
        vecs.push_back(mk(0,1,1,7'h7D,0, 1,0,1, 1,0,14'h3EFE));
        vecs.push_back(mk(0,1,1,7'h55,0, 0,0,1, 0,0,14'h3EFE));

        // Reset values.
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_seq_err", 32'(bus.seq_err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'(WAIT_LSB));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Asynchronous reset while FULL, away from any clock edge.
        chk("full_before_rst", 32'(bus.out_valid), 32'd1);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_out_data", 32'(bus.out_data), 32'd0);
        chk("async_seq_err", 32'(bus.seq_err), 32'd0);
        chk("async_err_count", 32'(bus.err_count), 32'd0);
        chk("async_state", 32'(bus.dbg_state), 32'(WAIT_LSB));
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // A word after the reset.
        apply_vec(mk(0,1,0,7'h15,1, 1,0,0, 0,0,14'h0000));
        apply_vec(mk(0,1,1,7'h2A,1, 1,0,1, 1,0,14'h1515));
        apply_vec(mk(0,0,0,7'h00,1, 1,0,0, 0,0,14'h0000));

        // Many consecutive msb-first errors: the counter saturates, or stays 0 when not built.
        for (int i = 0; i < 300; i++)
            apply_vec(mk(0,1,1,7'($urandom_range(0, 127)),1, 1,1,0, 0,0,14'h0000));
        chk("err_count_final", 32'(bus.err_count), CNT_ON ? 32'd255 : 32'd0);

        // Flush must not clear the counter.
        apply_vec(mk(1,0,0,7'h00,1, 0,0,0, 0,0,14'h0000));
        chk("err_count_after_flush", 32'(bus.err_count), CNT_ON ? 32'd255 : 32'd0);

        chk("words_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/half_joiner.md
# half_joiner

Receive-side counterpart of the pipeline's half-word select mux. The mux chooses the `msb` or `lsb` half of a word from `dec` (0 = lsb, 1 = msb). This block takes such halves one at a time over a valid/ready stream, lsb first and then msb. It rebuilds the full `2*nbits` word and presents it on a registered valid/ready output. It sits at the far end of any narrow `nbits` path in the pipeline, e.g. between a 7-bit transfer stage and the 14-bit consumer.

## Interface
- `nbits`, default 7: width of one half. The output word is `2*nbits` bits.
- `clk` input 1: the single clock; everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear; discards any partial or held word.
- `in_data` input `nbits`: incoming half.
- `in_msb` input 1: half tag, same encoding as `dec`. 0 = lsb half, 1 = msb half.
- `in_valid` input 1: `in_data` and `in_msb` are valid this cycle.
- `in_ready` output 1: the block accepts a half this cycle.
- `out_data` output `2*nbits`: assembled word, `{msb, lsb}`.
- `out_valid` output 1: `out_data` holds a complete word.
- `out_ready` input 1: the consumer accepts `out_data` this cycle.
- `seq_err` output 1: one-cycle pulse when a half arrives out of order.
- `err_count` output 8: saturating count of sequence errors. See Configuration.

## Operation
- **Transfers.** An input transfer happens when `in_valid && in_ready`. An output transfer happens when `out_valid && out_ready`.
- **States:**
  - `WAIT_LSB`: the reset state.
  - `WAIT_MSB`
  - `FULL`
- **WAIT_LSB:**
  - Accepting an lsb half stores it in `lsb_q` and moves to WAIT_MSB.
  - Accepting an msb half drops it, pulses `seq_err`, and stays in WAIT_LSB.
- **WAIT_MSB:**
  - Accepting an msb half loads `out_data = {in_data, lsb_q}`, sets `out_valid`, and moves to FULL.
  - Accepting an lsb half overwrites `lsb_q`, pulses `seq_err`, and stays in WAIT_MSB. The newest lsb wins.
- **FULL:**
  - `out_data` is held stable.
  - An output transfer clears `out_valid` and moves to WAIT_LSB.
- **`in_ready`** is 1 in WAIT_LSB and WAIT_MSB. In FULL it is 1 only when `out_ready` is also 1, which allows back-to-back streaming. A half accepted in that cycle is handled as in WAIT_LSB.
- **Flush.** `flush` forces WAIT_LSB, clears `out_valid` and drops `lsb_q`. An input presented in the same cycle as `flush` is ignored (`in_ready` = 0). Flush takes priority over every other event.
- **No arithmetic.** There is no width conversion beyond concatenation, and `out_data` bit positions are fixed.

## Timing
- **Reset values:**
  - State: WAIT_LSB.
  - `out_valid` = 0, `out_data` = 0, `lsb_q` = 0.
  - `seq_err` = 0, `err_count` = 0.
  - `in_ready` = 1 once `rst_n` is released.
- **Reset mid-word.** Asserting `rst_n` low asynchronously discards the partial or held word. No output transfer completes in that cycle.
- **Latency.** If the msb is accepted at edge N, then `out_valid` = 1 and `out_data` are valid just after edge N. A word therefore takes a minimum of 2 cycles from its lsb.
- **Throughput.** One word per 2 cycles with `out_ready` held at 1.
- **Output rules.** `out_valid` never drops without an output transfer, a flush or a reset. `out_data` does not change while `out_valid && !out_ready`.
- **Error pulse.** `seq_err` is registered and is high for exactly the cycle after the offending edge.
- **Input outputs.** `in_ready` is combinational from the state and `out_ready`. It does not depend on `in_valid`.

## Configuration
- **Macro `HALF_JOINER_ERRCNT_EN`.**
  - Defined: `err_count` increments on each `seq_err` event and saturates at 255. Only reset clears it; `flush` does not.
  - Not defined: the counter is not built and `err_count` is tied to 0. `seq_err` is always present.

## Structure
- **Shared package.** The shared pipeline definitions include/package holds the state encodings (`WAIT_LSB` = 2'd0, `WAIT_MSB` = 2'd1, `FULL` = 2'd2) and the `ERRCNT_W` = 8 constant.
- **Sub-module.** One natural sub-module, `sat_counter`: an 8-bit saturating counter with an enable input, instantiated only under `HALF_JOINER_ERRCNT_EN`.
- **Top-level logic.** The FSM, the `lsb_q` register and the output register stay in the top module.

## Test plan
- **Basic word.** Reset, then lsb `7'h15` followed by msb `7'h2A`, `out_ready` = 1 → `out_data` = `14'h1515` (`{7'h2A, 7'h15}`), `out_valid` = 1 for one cycle, `seq_err` never set.
- **Backpressure.** Complete a word with `out_ready` = 0 for 5 cycles → `out_valid` and `out_data` stable and `in_ready` = 0 throughout. Then `out_ready` = 1 → one transfer, and `in_ready` = 1 in that cycle.
- **Order errors.**
  - msb `7'h01` in WAIT_LSB → `seq_err` pulses once and the half is dropped. lsb `7'h03`, msb `7'h04` then gives `out_data` = `14'h0203`.
  - Two lsb halves `7'h10`, `7'h11` then msb `7'h00` → one `seq_err` pulse and `out_data` = `14'h0011`.
- **Flush.** Flush in WAIT_MSB after lsb `7'h7F`, then msb `7'h01` → `seq_err` pulses and no word is produced. Flush asserted together with `in_valid` → input ignored, state WAIT_LSB.
- **Reset mid-operation.** Drop `rst_n` while in FULL → `out_valid` = 0 immediately, asynchronously, and all outputs take their reset values.
- **Error counter.** With `HALF_JOINER_ERRCNT_EN`, 300 consecutive msb-first errors → `err_count` = 255. Without the macro, `err_count` = 0 throughout.
